// File: rtl/wb_arbiter_2m_if.sv
// Wishbone link bundle used by the two-master arbiter: one instance per master port and one for the slave side.
interface wb_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   wdat;
    logic [DW-1:0]   rdat;
    logic            ack;
    logic            err;

    modport master (output cyc, stb, we, sel, adr, wdat, input ack, err, rdat);
    modport slave  (input cyc, stb, we, sel, adr, wdat, output ack, err, rdat);
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter, round-robin grant locked for the owner's whole cyc.
// Optional stall timeout (bus error to the owner) enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_arbiter_2m_if.slave  m0,
    wb_arbiter_2m_if.slave  m1,
    wb_arbiter_2m_if.master s,
    output logic [1:0]      grant_o,
    output logic            busy_o
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT must be in 1..255");
    end

    // Encoding doubles as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_last_gnt;
    logic            w_sel_stb;
    logic            w_err_pulse;
    logic            w_cyc;
    logic            w_we;
    logic [DW/8-1:0] w_sel;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_wdat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ST_GNT0)
                r_last_gnt <= 1'b0;
            else if (w_state_next == ST_GNT1)
                r_last_gnt <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc)
                    w_state_next = r_last_gnt ? ST_GNT0 : ST_GNT1;
                else if (m0.cyc)
                    w_state_next = ST_GNT0;
                else if (m1.cyc)
                    w_state_next = ST_GNT1;
            end
            // Handover goes straight to the other master when it is waiting.
            ST_GNT0: if (!m0.cyc) w_state_next = m1.cyc ? ST_GNT1 : ST_IDLE;
            ST_GNT1: if (!m1.cyc) w_state_next = m0.cyc ? ST_GNT0 : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Kept separate from the output mux so the timeout path never loops through it.
    always_comb begin
        case (r_state)
            ST_GNT0: w_sel_stb = m0.stb;
            ST_GNT1: w_sel_stb = m1.stb;
            default: w_sel_stb = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_tmo_cnt;

    assign w_err_pulse = w_sel_stb & ~s.ack & (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)
            r_tmo_cnt <= '0;
        else if (w_err_pulse || !w_sel_stb || s.ack || (w_state_next != r_state))
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
`else
    assign w_err_pulse = 1'b0;
`endif

    always_comb begin
        w_cyc   = 1'b0;
        w_we    = 1'b0;
        w_sel   = '0;
        w_adr   = '0;
        w_wdat  = '0;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m0.rdat = '0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        m1.rdat = '0;
        case (r_state)
            ST_GNT0: begin
                w_cyc   = m0.cyc;
                w_we    = m0.we;
                w_sel   = m0.sel;
                w_adr   = m0.adr;
                w_wdat  = m0.wdat;
                m0.ack  = s.ack & m0.stb & ~w_err_pulse;
                m0.err  = w_err_pulse;
                m0.rdat = s.rdat;
            end
            ST_GNT1: begin
                w_cyc   = m1.cyc;
                w_we    = m1.we;
                w_sel   = m1.sel;
                w_adr   = m1.adr;
                w_wdat  = m1.wdat;
                m1.ack  = s.ack & m1.stb & ~w_err_pulse;
                m1.err  = w_err_pulse;
                m1.rdat = s.rdat;
            end
            default: ;
        endcase
    end

    assign s.cyc   = w_cyc;
    assign s.stb   = w_sel_stb & ~w_err_pulse;
    assign s.we    = w_we;
    assign s.sel   = w_sel;
    assign s.adr   = w_adr;
    assign s.wdat  = w_wdat;
    assign grant_o = r_state;
    assign busy_o  = |r_state;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m: reset, single master, round-robin, lock, timeout, reset mid-burst.
module tb_wb_arbiter_2m;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) m0_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) m1_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) s_if ();

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant_o  (grant),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
        m0_if.sel = '0;   m0_if.adr = '0;   m0_if.wdat = '0;
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
        m1_if.sel = '0;   m1_if.adr = '0;   m1_if.wdat = '0;
        s_if.ack  = 1'b0; s_if.rdat = '0;   s_if.err = 1'b0;
    endtask

    task automatic apply_reset();
        idle_all();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
        m0_if.sel = 4'hF; m0_if.adr = 32'h0000_1234; m0_if.wdat = 32'hFFFF_FFFF;
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1;
        m1_if.sel = 4'hF; m1_if.adr = 32'h0000_5678; m1_if.wdat = 32'h5555_AAAA;
        s_if.ack = 1'b1;  s_if.rdat = 32'hDEAD_BEEF; s_if.err = 1'b0;
        repeat (3) step();
        mid();
        total++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_grant got grant=%b busy=%b exp grant=00 busy=0", grant, busy);
        end
        total++;
        if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b000 || s_if.sel !== 4'h0 || s_if.adr !== 32'h0 || s_if.wdat !== 32'h0) begin
            bad++; $display("FAIL reset_slave got cyc/stb/we=%b%b%b sel=%h adr=%h dat=%h exp all 0",
                            s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.wdat);
        end
        total++;
        if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0000 || m0_if.rdat !== 32'h0 || m1_if.rdat !== 32'h0) begin
            bad++; $display("FAIL reset_master got ack/err m0=%b%b m1=%b%b rdat0=%h rdat1=%h exp all 0",
                            m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, m0_if.rdat, m1_if.rdat);
        end
        $display("txn reset: grant=%b busy=%b", grant, busy);
        idle_all();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
        m0_if.sel = 4'hF; m0_if.adr = 32'h0002_0004; m0_if.wdat = 32'hA5A5_1234;
        mid();
        total++;
        if (grant !== 2'b00 || s_if.cyc !== 1'b0) begin
            bad++; $display("FAIL single_latency got grant=%b s_cyc=%b exp grant=00 s_cyc=0", grant, s_if.cyc);
        end
        step();
        mid();
        total++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            bad++; $display("FAIL single_grant got grant=%b busy=%b exp grant=01 busy=1", grant, busy);
        end
        total++;
        if (s_if.adr !== 32'h0002_0004 || s_if.wdat !== 32'hA5A5_1234 || s_if.we !== 1'b1 ||
            s_if.sel !== 4'hF || s_if.cyc !== 1'b1 || s_if.stb !== 1'b1) begin
            bad++; $display("FAIL single_fields got adr=%h dat=%h we=%b sel=%h cyc=%b stb=%b exp 00020004 a5a51234 1 f 1 1",
                            s_if.adr, s_if.wdat, s_if.we, s_if.sel, s_if.cyc, s_if.stb);
        end
        total++;
        if (m0_if.ack !== 1'b0) begin
            bad++; $display("FAIL single_noack got m0_ack=%b exp 0", m0_if.ack);
        end
        s_if.ack = 1'b1;
        #1;
        total++;
        if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin
            bad++; $display("FAIL single_ack got m0_ack=%b m1_ack=%b exp m0_ack=1 m1_ack=0", m0_if.ack, m1_if.ack);
        end
        step();
        idle_all();
        #1;
        total++;
        if (s_if.cyc !== 1'b0 || grant !== 2'b01) begin
            bad++; $display("FAIL single_drop got s_cyc=%b grant=%b exp s_cyc=0 grant=01", s_if.cyc, grant);
        end
        step();
        mid();
        total++;
        if (grant !== 2'b00) begin
            bad++; $display("FAIL single_release got grant=%b exp 00", grant);
        end
        $display("txn single write: adr=00020004 dat=a5a51234 grant=%b", grant);
    endtask

    task automatic test_round_robin();
        apply_reset();
        m0_if.cyc = 1'b1;
        m1_if.cyc = 1'b1;
        step();
        mid();
        total++;
        if (grant !== 2'b01) begin
            bad++; $display("FAIL rr_first got grant=%b exp 01", grant);
        end
        step();
        m0_if.cyc = 1'b0;
        mid();
        total++;
        if (grant !== 2'b01 || s_if.cyc !== 1'b0) begin
            bad++; $display("FAIL rr_pre_handover got grant=%b s_cyc=%b exp grant=01 s_cyc=0", grant, s_if.cyc);
        end
        step();
        mid();
        total++;
        if (grant !== 2'b10 || s_if.cyc !== 1'b1) begin
            bad++; $display("FAIL rr_handover got grant=%b s_cyc=%b exp grant=10 s_cyc=1", grant, s_if.cyc);
        end
        step();
        m1_if.cyc = 1'b0;
        step();
        mid();
        total++;
        if (grant !== 2'b00) begin
            bad++; $display("FAIL rr_idle got grant=%b exp 00", grant);
        end
        step();
        m0_if.cyc = 1'b1;
        m1_if.cyc = 1'b1;
        step();
        mid();
        total++;
        if (grant !== 2'b01) begin
            bad++; $display("FAIL rr_second got grant=%b exp 01", grant);
        end
        $display("txn round robin: final grant=%b", grant);
        idle_all();
        step();
        step();
    endtask

    task automatic test_lock();
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        idle_all();
        step();
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b0;
        m1_if.sel = 4'hF; m1_if.adr = 32'h0002_0000;
        step();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1; m0_if.adr = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            exp_adr = 32'h0002_0000 + 32'(i * 4);
            exp_dat = 32'hCAFE_0000 + 32'(i);
            m1_if.adr = exp_adr;
            s_if.ack = 1'b1;
            s_if.rdat = exp_dat;
            mid();
            total++;
            if (grant !== 2'b10 || s_if.adr !== exp_adr || s_if.we !== 1'b0) begin
                bad++; $display("FAIL lock_bus[%0d] got grant=%b adr=%h we=%b exp grant=10 adr=%h we=0",
                                i, grant, s_if.adr, s_if.we, exp_adr);
            end
            total++;
            if (m1_if.ack !== 1'b1 || m1_if.rdat !== exp_dat) begin
                bad++; $display("FAIL lock_read[%0d] got ack=%b dat=%h exp ack=1 dat=%h", i, m1_if.ack, m1_if.rdat, exp_dat);
            end
            total++;
            if (m0_if.ack !== 1'b0 || m0_if.rdat !== 32'h0) begin
                bad++; $display("FAIL lock_m0_quiet[%0d] got ack=%b dat=%h exp ack=0 dat=0", i, m0_if.ack, m0_if.rdat);
            end
            $display("txn lock read %0d: adr=%h dat=%h grant=%b", i, s_if.adr, m1_if.rdat, grant);
            step();
        end
        m1_if.cyc = 1'b0;
        m1_if.stb = 1'b0;
        s_if.ack = 1'b0;
        mid();
        total++;
        if (grant !== 2'b10) begin
            bad++; $display("FAIL lock_hold got grant=%b exp 10", grant);
        end
        step();
        mid();
        total++;
        if (grant !== 2'b01 || s_if.adr !== 32'h0000_0055 || m0_if.ack !== 1'b0) begin
            bad++; $display("FAIL lock_m0_after got grant=%b adr=%h ack=%b exp grant=01 adr=00000055 ack=0",
                            grant, s_if.adr, m0_if.ack);
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_timeout();
        int  n_err;
        logic exp_err;
        idle_all();
        step();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
        m0_if.sel = 4'hF; m0_if.adr = 32'h0003_0000; m0_if.wdat = 32'h1357_9BDF;
        step();
        n_err = 0;
        for (int k = 1; k <= 20; k++) begin
            exp_err = TMO_EN && (k == TMO);
            mid();
            total++;
            if (m0_if.err !== exp_err || s_if.stb !== !exp_err) begin
                bad++; $display("FAIL timeout_cycle[%0d] got err=%b s_stb=%b exp err=%b s_stb=%b",
                                k, m0_if.err, s_if.stb, exp_err, !exp_err);
            end
            total++;
            if (m0_if.ack !== 1'b0 || grant !== 2'b01) begin
                bad++; $display("FAIL timeout_state[%0d] got ack=%b grant=%b exp ack=0 grant=01", k, m0_if.ack, grant);
            end
            if (m0_if.err === 1'b1)
                n_err++;
            step();
        end
        total++;
        if (n_err !== (TMO_EN ? 1 : 0)) begin
            bad++; $display("FAIL timeout_count got pulses=%0d exp %0d", n_err, TMO_EN ? 1 : 0);
        end
        $display("txn timeout stall: err pulses=%0d over 20 cycles", n_err);
        idle_all();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        idle_all();
        step();
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1;
        m1_if.sel = 4'h3; m1_if.adr = 32'h0004_0000; m1_if.wdat = 32'h0BAD_F00D;
        s_if.ack = 1'b1;
        step();
        mid();
        total++;
        if (grant !== 2'b10 || s_if.stb !== 1'b1 || m1_if.ack !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre got grant=%b s_stb=%b ack=%b exp grant=10 s_stb=1 ack=1",
                            grant, s_if.stb, m1_if.ack);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 2'b00 || busy !== 1'b0 || s_if.cyc !== 1'b0 || s_if.stb !== 1'b0 ||
            s_if.adr !== 32'h0 || m1_if.ack !== 1'b0) begin
            bad++; $display("FAIL rstmid_async got grant=%b busy=%b cyc=%b stb=%b adr=%h ack=%b exp all 0",
                            grant, busy, s_if.cyc, s_if.stb, s_if.adr, m1_if.ack);
        end
        m0_if.cyc = 1'b1;
        s_if.ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        mid();
        total++;
        if (grant !== 2'b01) begin
            bad++; $display("FAIL rstmid_after got grant=%b exp 01", grant);
        end
        $display("txn reset mid-burst: grant after release=%b", grant);
        idle_all();
        step();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion exp finish before 100000");
        $fatal(1);
    end

endmodule
